bias_stream_buf: RTL and testbench
==================================

# bias_stream_buf

Parametrised multi-lane bias buffer for the int8 datapath. The global buffer loads per-channel 32-bit bias words one at a time through a write port. A burst reader streams groups of LANES consecutive words to the PE array's post-accumulation stage through a valid/ready handshake. Generalises the single-shot eight-word bias SRAM with configurable depth, width and lane count, modulo wrap-around addressing, multi-group bursts with back-pressure, and optional write-to-read forwarding.

## Interface
- DEPTH, 4096, number of words; power of two.
- DATA_W, 32, bits per bias word.
- LANES, 8, words delivered per output group; power of two, LANES ≤ DEPTH.
- ADDR_W, $clog2(DEPTH), address width (derived).
- LEN_W, 12, width of burst-length field.

- CLK  in  1  clock; all state changes on rising edge.
- RSTn  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe; one word per cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_req  in  1  burst start request.
- rd_addr  in  ADDR_W  burst base address; any alignment.
- rd_len  in  LEN_W  number of groups in the burst.
- rd_busy  out  1  burst in progress.
- out_valid  out  1  out_data holds a valid group.
- out_ready  in  1  consumer accepts group.
- out_data  out  DATA_W × LANES (unpacked [0:LANES-1])  lane i = word at ptr+i mod DEPTH.
- out_last  out  1  qualifies final group of burst.

## Operation
- Storage: DEPTH × DATA_W array, not reset.
- Writes are accepted every cycle wr_en=1, independent of read state, including during bursts.
- FSM states: IDLE and RUN.
- IDLE: rd_req=1 with rd_len≠0 latches ptr←rd_addr and remaining←rd_len, then enters RUN, and performs the fetch of group 0 on the same edge. rd_req with rd_len=0 is ignored.
- RUN: the output register loads on any edge where (out_valid=0 or out_ready=1) and remaining≠0.
  - Load: out_data[i]←ram[(ptr+i) mod DEPTH], ptr←(ptr+LANES) mod DEPTH, remaining−1.
  - out_last=1 when the loaded group is the last (remaining was 1).
- Handshake: a group transfers on an edge with out_valid=1 and out_ready=1.
  - out_valid, out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid drops only after a transfer with no refill.
- RUN→IDLE on transfer of the group with out_last=1. rd_busy=1 exactly while in RUN.
- rd_req while rd_busy=1 is ignored; no queueing.
- Wrap-around: address arithmetic is modulo DEPTH per lane. A group straddling DEPTH−1→0 returns words from both ends.
- Write/read collision on the same edge, same address: see Configuration.

## Timing
- Reset values: out_valid=0, out_last=0, out_data all 0, rd_busy=0, state IDLE, ptr=0, remaining=0.
- Latency: rd_req sampled at edge k gives out_valid=1 with group 0 after edge k.
- Throughput: one group per cycle while out_ready=1. A burst of N groups completes in N cycles with no stalls.
- Stall: group n+1 is fetched at the edge that transfers group n. No bubble, no data loss.
- Reset asserted mid-burst aborts on that edge: all outputs return to reset values and the remaining groups are discarded.
- Write then read, different edges: a write at edge k is visible to any fetch at edge k+1 or later.

## Configuration
- BIAS_STREAM_FWD_EN defined: when wr_en is asserted on the same edge as a fetch and wr_addr matches a lane's address, that lane loads wr_data (write-first).
- Undefined: that lane loads the pre-write array content (read-first). The write still commits.

## Test plan
- Preload ram[k]=k+0x100 for k=0..63. Request rd_addr=0, rd_len=2, out_ready=1 → group 0 is 0x100..0x107 after the first edge, group 1 is 0x108..0x10F with out_last=1, rd_busy drops after that transfer.
- rd_addr=DEPTH−3, rd_len=1 → lanes 0–2 = ram[DEPTH−3..DEPTH−1], lanes 3–7 = ram[0..4], out_last=1.
- Burst rd_len=4 with out_ready low for 3 cycles on group 1 → group 1 held stable and all 4 groups delivered in order, no duplicates. A rd_req issued mid-burst is ignored.
- Write 0xDEAD to address 5 on the fetch edge of the group at base 0:
  - macro defined → lane 5 = 0xDEAD;
  - macro undefined → lane 5 = old value; the next read of 5 returns 0xDEAD.
- RSTn=0 during the third group of a rd_len=8 burst → next cycle out_valid=0, rd_busy=0, out_data=0. A new request then starts cleanly from its base. rd_len=0 request → no output, rd_busy stays 0.

Source files
------------

// File: rtl/bias_stream_buf.sv
`default_nettype none
// ============================================================================
// Module   : bias_stream_buf
// Purpose  : Multi-lane bias buffer. A single-word write port loads bias words.
//            A burst reader streams groups of LANES consecutive words, with
//            wrap-around modulo DEPTH, over a valid/ready handshake.
// Options  : BIAS_STREAM_FWD_EN  - when defined, a write on the same edge as a
//            fetch forwards wr_data into the matching lane (write-first).
//            Otherwise that lane returns the old array content (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module bias_stream_buf #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data [0:LANES-1],
  output logic              out_last
);

  // Pointer advance per group. Truncation gives the modulo-DEPTH step.
  localparam logic [ADDR_W-1:0] c_LANES_STEP = ADDR_W'(LANES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_ram [0:DEPTH-1];
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_out_data [0:LANES-1];

  logic              w_xfer;
  logic              w_load;
  logic              w_load_last;
  logic [ADDR_W-1:0] w_base;
  logic [LEN_W-1:0]  w_rem_src;
  logic [DATA_W-1:0] w_fetch [0:LANES-1];

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and fetch control. In IDLE the burst parameters come straight
  // from the request, so group 0 is fetched on the accepting edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_base      = r_ptr;
    w_rem_src   = r_remaining;
    w_xfer      = r_out_valid && out_ready;
    case (r_state)
      S_IDLE: begin
        if (rd_req && (rd_len != '0)) begin
          w_load      = 1'b1;
          w_base      = rd_addr;
          w_rem_src   = rd_len;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((!r_out_valid || out_ready) && (r_remaining != '0)) begin
          w_load = 1'b1;
        end
        if (w_xfer && r_out_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_load_last = (w_rem_src == LEN_W'(1));
  end

  // Per-lane read address with modulo-DEPTH wrap; optional write forwarding.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ADDR_W-1:0] w_lane_addr;
    assign w_lane_addr = w_base + ADDR_W'(gi);
`ifdef BIAS_STREAM_FWD_EN
    assign w_fetch[gi] = (wr_en && (wr_addr == w_lane_addr)) ? wr_data
                                                             : r_ram[w_lane_addr];
`else
    assign w_fetch[gi] = r_ram[w_lane_addr];
`endif
  end

  // Storage array: written every strobed cycle, never reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      r_ram[wr_addr] <= wr_data;
    end
  end

  // Output group register, burst pointer and group countdown.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_out_data[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < LANES; i++) begin
        r_out_data[i] <= w_fetch[i];
      end
      r_ptr       <= w_base + c_LANES_STEP;
      r_remaining <= w_rem_src - LEN_W'(1);
      r_out_valid <= 1'b1;
      r_out_last  <= w_load_last;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign rd_busy   = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_bias_stream_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_stream_buf
// Purpose  : Scoreboard bench for bias_stream_buf. Requests push expected
//            groups computed from a word-array model; a negedge monitor pops
//            and compares each transferred group and checks hold stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bias_stream_buf;

  localparam int DEPTH  = 4096;
  localparam int DATA_W = 32;
  localparam int LANES  = 8;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 12;
  localparam int GW     = DATA_W * LANES;

  logic              CLK       = 1'b0;
  logic              RSTn      = 1'b0;
  logic              wr_en     = 1'b0;
  logic [ADDR_W-1:0] wr_addr   = '0;
  logic [DATA_W-1:0] wr_data   = '0;
  logic              rd_req    = 1'b0;
  logic [ADDR_W-1:0] rd_addr   = '0;
  logic [LEN_W-1:0]  rd_len    = '0;
  logic              out_ready = 1'b1;
  logic              rd_busy;
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] out_data [0:LANES-1];

  bias_stream_buf #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .LANES (LANES),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mdl [DEPTH];
  logic [GW:0]       exp_q [$];
  bit                mon_en = 1'b0;

  function automatic logic [GW-1:0] flat();
    logic [GW-1:0] f;
    for (int i = 0; i < LANES; i++) f[i*DATA_W +: DATA_W] = out_data[i];
    return f;
  endfunction

  task automatic chk1(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chkg(input bit ok, input string nm, input logic [GW:0] act, input logic [GW:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every transferred group, check groups held under stall.
  logic [GW:0] held;
  bit          hold_pend = 1'b0;
  bit          busy_chk  = 1'b0;
  always @(negedge CLK) begin
    logic [GW:0] act;
    logic [GW:0] e;
    act = {out_last, flat()};
    if (!mon_en) begin
      hold_pend = 1'b0;
      busy_chk  = 1'b0;
    end else begin
      if (busy_chk) begin
        chk1(rd_busy == 1'b0, "busy_after_last", int'(rd_busy), 0);
        busy_chk = 1'b0;
      end
      if (hold_pend) chkg(out_valid && (act == held), "hold_stable", act, held);
      if (out_valid && out_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          chkg(1'b0, "unexpected_group", act, '0);
        end else begin
          e = exp_q.pop_front();
          chkg(act == e, "group", act, e);
          if (e[GW]) busy_chk = 1'b1;
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        held      = act;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    mdl[a]  = d;
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  // Issue a request (optionally with a write on the same edge) and queue the
  // expected groups. Group 0 is fetched on the request edge; later groups see
  // the committed write.
  task automatic request(input int base, input int len, input bit wr,
                         input int waddr, input logic [DATA_W-1:0] wdata);
    logic [GW:0]       g;
    int                a;
    logic [DATA_W-1:0] v;
    rd_req  = 1'b1;
    rd_addr = ADDR_W'(base);
    rd_len  = LEN_W'(len);
    wr_en   = wr;
    wr_addr = ADDR_W'(waddr);
    wr_data = wdata;
    for (int n = 0; n < len; n++) begin
      for (int i = 0; i < LANES; i++) begin
        a = (base + n * LANES + i) % DEPTH;
        v = mdl[a];
`ifdef BIAS_STREAM_FWD_EN
        if (n == 0 && wr && a == waddr) v = wdata;
`endif
        g[i*DATA_W +: DATA_W] = v;
      end
      g[GW] = (n == len - 1);
      exp_q.push_back(g);
      if (n == 0 && wr) mdl[waddr] = wdata;
    end
    if (len == 0 && wr) mdl[waddr] = wdata;
    @(posedge CLK); #1;
    rd_req = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input bit rnd);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || rd_busy) && c < bound) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      c++;
    end
    out_ready = 1'b1;
    chk1(c < bound, "drain_timeout", c, bound);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    int len;
    int a;
    bit wr;
    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk1(out_valid == 1'b0, "rst_valid", int'(out_valid), 0);
    chk1(out_last == 1'b0, "rst_last", int'(out_last), 0);
    chk1(rd_busy == 1'b0, "rst_busy", int'(rd_busy), 0);
    chkg(flat() == '0, "rst_data", {1'b0, flat()}, '0);
    RSTn   = 1'b1;
    mon_en = 1'b1;

    // Preload both ends of the array.
    for (int k = 0; k < 64; k++) do_write(k, DATA_W'(k + 'h100));
    for (int k = DEPTH - 64; k < DEPTH; k++) do_write(k, DATA_W'(k + 'hA000));

    // Two-group burst at full rate.
    request(0, 2, 1'b0, 0, '0);
    chk1(out_valid == 1'b1, "lat_valid", int'(out_valid), 1);
    chk1(out_last == 1'b0, "g0_not_last", int'(out_last), 0);
    @(posedge CLK); #1;
    chk1(out_valid && out_last, "g1_last", int'({out_valid, out_last}), 3);
    @(posedge CLK); #1;
    chk1(!rd_busy && !out_valid, "t1_done", int'({rd_busy, out_valid}), 0);
    wait_drain(20, 1'b0);

    // Group straddling the top of the array.
    request(DEPTH - 3, 1, 1'b0, 0, '0);
    wait_drain(20, 1'b0);

    // Stall on group 1 for 3 cycles, with an ignored mid-burst request.
    request(16, 4, 1'b0, 0, '0);
    @(posedge CLK); #1;
    out_ready = 1'b0;
    rd_req    = 1'b1;
    rd_addr   = ADDR_W'(40);
    rd_len    = LEN_W'(3);
    @(posedge CLK); #1;
    rd_req = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    out_ready = 1'b1;
    wait_drain(20, 1'b0);
    repeat (4) begin @(posedge CLK); #1; end
    chk1(rd_busy == 1'b0, "no_queued_req", int'(rd_busy), 0);

    // Write/read collision on the fetch edge, then a plain re-read.
    request(0, 1, 1'b1, 5, 32'hDEAD);
    wait_drain(20, 1'b0);
    request(0, 1, 1'b0, 0, '0);
    wait_drain(20, 1'b0);

    // Reset during the third group of an 8-group burst.
    request(0, 8, 1'b0, 0, '0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mon_en    = 1'b0;
    out_ready = 1'b0;
    RSTn      = 1'b0;
    @(posedge CLK); #1;
    chk1(out_valid == 1'b0, "abort_valid", int'(out_valid), 0);
    chk1(rd_busy == 1'b0, "abort_busy", int'(rd_busy), 0);
    chkg(flat() == '0, "abort_data", {out_last, flat()}, '0);
    exp_q.delete();
    RSTn      = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    request(24, 2, 1'b0, 0, '0);
    wait_drain(20, 1'b0);

    // Zero-length request produces nothing.
    request(8, 0, 1'b0, 0, '0);
    repeat (3) begin @(posedge CLK); #1; end
    chk1(!rd_busy && !out_valid, "len0_ignored", int'({rd_busy, out_valid}), 0);

    // Randomised writes, bursts and back-pressure around the wrap point.
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        a = int'($urandom_range(0, 127));
        if (a >= 64) a = DEPTH - 128 + a;
        do_write(a, $urandom);
      end
      base = DEPTH - 40 + int'($urandom_range(0, 39));
      len  = int'($urandom_range(1, 4));
      wr   = 1'($urandom_range(0, 1));
      a    = (base + int'($urandom_range(0, LANES * len - 1))) % DEPTH;
      request(base, len, wr, a, $urandom);
      wait_drain(200, 1'b1);
    end
    repeat (3) begin @(posedge CLK); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
